// File: rtl/i2s_clk_gen.sv
// Audio serial-clock generator: NCO-driven BCLK plus LRCLK/FS and slot/bit counters.
// All outputs are registered; bclk_rise/bclk_fall act as clock enables for the serialiser.
module i2s_clk_gen #(
  parameter int unsigned     ACC_W    = 32,
  parameter longint unsigned INC      = 242431318,
  parameter int unsigned     SLOT_W   = 32,
  parameter int unsigned     CHANNELS = 2,
  parameter int unsigned     MODE     = 0,
  localparam int unsigned    CW       = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1,
  localparam int unsigned    BW       = ($clog2(SLOT_W) > 1) ? $clog2(SLOT_W) : 1
) (
  input  logic          refclk_i,
  input  logic          rst_i,
  input  logic          en_i,
  output logic          bclk_o,
  output logic          lrclk_o,
  output logic          bclk_rise_o,
  output logic          bclk_fall_o,
  output logic          frame_start_o,
  output logic [CW-1:0] slot_idx_o,
  output logic [BW-1:0] bit_idx_o,
  output logic          locked_o
);

  if (INC < 1 || INC >= (64'd1 << (ACC_W - 1)) || SLOT_W < 2 || CHANNELS < 2 || MODE > 2 ||
      (MODE != 2 && (CHANNELS % 2) != 0)) begin : g_bad_param
    $error("i2s_clk_gen: illegal parameter combination");
  end

  localparam logic [ACC_W-1:0] INC_V     = ACC_W'(INC);
  localparam logic [BW-1:0]    BIT_LAST  = BW'(SLOT_W - 1);
  localparam logic [CW-1:0]    SLOT_LAST = CW'(CHANNELS - 1);
  localparam logic [CW-1:0]    HALF      = CW'(CHANNELS / 2);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             carry, fall, wrap;
  logic             bclk_q, lrclk_q, lrclk_d, rise_q, fall_q, fs_q, locked_q;
  logic             seen_q, first_q;
  logic [CW-1:0]    slot_q, slot_d, slot_after;
  logic [BW-1:0]    bit_q, bit_d;

  always_comb begin
    {carry, acc_d} = {1'b0, acc_q} + {1'b0, INC_V};
    fall   = carry & bclk_q;
    bit_d  = (bit_q == BIT_LAST) ? '0 : bit_q + 1'b1;
    slot_d = slot_q;
    if (bit_q == BIT_LAST) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    wrap       = (bit_d == '0) && (slot_d == '0);
    slot_after = (slot_d == SLOT_LAST) ? '0 : slot_d + 1'b1;
    lrclk_d    = lrclk_q;
    if (MODE == 0) begin
      // WS leads the data by one bit: switch on the last bit of the preceding slot
      if (bit_d == BIT_LAST) lrclk_d = (slot_after >= HALF);
    end else if (MODE == 1) begin
      if (bit_d == '0) lrclk_d = (slot_d >= HALF);
    end else begin
      if (first_q)                                       lrclk_d = 1'b1;
      else if (lrclk_q)                                  lrclk_d = 1'b0;
      else if (bit_d == BIT_LAST && slot_d == SLOT_LAST) lrclk_d = 1'b1;
    end
  end

  always_ff @(posedge refclk_i) begin
    if (rst_i || !en_i) begin
      acc_q    <= '0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      fs_q     <= 1'b0;
      locked_q <= 1'b0;
      seen_q   <= 1'b0;
      first_q  <= 1'b1;
      slot_q   <= SLOT_LAST;
      bit_q    <= BIT_LAST;
    end else begin
      acc_q  <= acc_d;
      rise_q <= carry & ~bclk_q;
      fall_q <= fall;
      fs_q   <= fall & wrap;
      if (carry) bclk_q <= ~bclk_q;
      if (fall) begin
        bit_q   <= bit_d;
        slot_q  <= slot_d;
        lrclk_q <= lrclk_d;
        first_q <= 1'b0;
      end
      // lock on the second frame_start strobe seen since enable
      if (fs_q) begin
        seen_q <= 1'b1;
        if (seen_q) locked_q <= 1'b1;
      end
    end
  end

  assign bclk_o        = bclk_q;
  assign lrclk_o       = lrclk_q;
  assign bclk_rise_o   = rise_q;
  assign bclk_fall_o   = fall_q;
  assign frame_start_o = fs_q;
  assign slot_idx_o    = slot_q;
  assign bit_idx_o     = bit_q;
  assign locked_o      = locked_q;

endmodule

// File: tb/tb_i2s_clk_gen.sv
// Directed bench for i2s_clk_gen: four configurations sharing clock, reset and enable.
module tb_i2s_clk_gen;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  localparam longint unsigned INC_F = 242431318;

  logic a_bclk, a_lr, a_rise, a_fall, a_fs, a_lock; logic [0:0] a_slot; logic [1:0] a_bit;
  logic b_bclk, b_lr, b_rise, b_fall, b_fs, b_lock; logic [0:0] b_slot; logic [1:0] b_bit;
  logic c_bclk, c_lr, c_rise, c_fall, c_fs, c_lock; logic [2:0] c_slot; logic [4:0] c_bit;
  logic d_bclk, d_lr, d_rise, d_fall, d_fs, d_lock; logic [0:0] d_slot; logic [4:0] d_bit;

  i2s_clk_gen #(.ACC_W(32), .INC(64'd1 << 30), .SLOT_W(4), .CHANNELS(2), .MODE(0)) u_i2s (
    .refclk_i(clk), .rst_i(rst), .en_i(en), .bclk_o(a_bclk), .lrclk_o(a_lr),
    .bclk_rise_o(a_rise), .bclk_fall_o(a_fall), .frame_start_o(a_fs),
    .slot_idx_o(a_slot), .bit_idx_o(a_bit), .locked_o(a_lock));

  i2s_clk_gen #(.ACC_W(32), .INC(64'd1 << 30), .SLOT_W(4), .CHANNELS(2), .MODE(1)) u_lj (
    .refclk_i(clk), .rst_i(rst), .en_i(en), .bclk_o(b_bclk), .lrclk_o(b_lr),
    .bclk_rise_o(b_rise), .bclk_fall_o(b_fall), .frame_start_o(b_fs),
    .slot_idx_o(b_slot), .bit_idx_o(b_bit), .locked_o(b_lock));

  i2s_clk_gen #(.ACC_W(32), .INC(64'd1 << 30), .SLOT_W(32), .CHANNELS(8), .MODE(2)) u_tdm (
    .refclk_i(clk), .rst_i(rst), .en_i(en), .bclk_o(c_bclk), .lrclk_o(c_lr),
    .bclk_rise_o(c_rise), .bclk_fall_o(c_fall), .frame_start_o(c_fs),
    .slot_idx_o(c_slot), .bit_idx_o(c_bit), .locked_o(c_lock));

  i2s_clk_gen u_frac (
    .refclk_i(clk), .rst_i(rst), .en_i(en), .bclk_o(d_bclk), .lrclk_o(d_lr),
    .bclk_rise_o(d_rise), .bclk_fall_o(d_fall), .frame_start_o(d_fs),
    .slot_idx_o(d_slot), .bit_idx_o(d_bit), .locked_o(d_lock));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // after this, the next rising edge is cycle 1 of the enabled run
  task automatic do_reset();
    en = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int r1, r2;
    en = 1'b1; rst = 1'b1;
    repeat (3) tick();
    n_chk++;
    if ({a_bclk, a_lr, a_rise, a_fall, a_fs, a_lock, b_bclk, b_lr, b_rise, b_fall, b_fs, b_lock} !== 12'b0) begin
      n_fail++; $display("FAIL reset_ab_outputs: got %b expected 0",
        {a_bclk, a_lr, a_rise, a_fall, a_fs, a_lock, b_bclk, b_lr, b_rise, b_fall, b_fs, b_lock});
    end
    n_chk++;
    if ({c_bclk, c_lr, c_rise, c_fall, c_fs, c_lock, d_bclk, d_lr, d_rise, d_fall, d_fs, d_lock} !== 12'b0) begin
      n_fail++; $display("FAIL reset_cd_outputs: got %b expected 0",
        {c_bclk, c_lr, c_rise, c_fall, c_fs, c_lock, d_bclk, d_lr, d_rise, d_fall, d_fs, d_lock});
    end
    n_chk++;
    if (a_slot !== 1'b1 || a_bit !== 2'd3 || b_slot !== 1'b1 || b_bit !== 2'd3 ||
        c_slot !== 3'd7 || c_bit !== 5'd31 || d_slot !== 1'b1 || d_bit !== 5'd31) begin
      n_fail++; $display("FAIL reset_preframe: got a=%0d/%0d c=%0d/%0d d=%0d/%0d expected 1/3 7/31 1/31",
        a_slot, a_bit, c_slot, c_bit, d_slot, d_bit);
    end
    rst = 1'b0;
    r1 = -1; r2 = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (a_rise) begin
        if (r1 < 0) r1 = c;
        else if (r2 < 0) r2 = c;
      end
    end
    n_chk++;
    if (r1 != 4) begin n_fail++; $display("FAIL reset_first_rise: got cycle %0d expected 4", r1); end
    n_chk++;
    if (r2 - r1 != 8) begin n_fail++; $display("FAIL reset_bclk_period: got %0d expected 8", r2 - r1); end
  endtask

  task automatic test_i2s();
    int fs[3]; int nfs, lr_r, lr_f, lk, r_slot, r_bit;
    logic prev;
    do_reset();
    nfs = 0; lr_r = -1; lr_f = -1; lk = -1; r_slot = -1; r_bit = -1; prev = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (a_fs && nfs < 3) begin fs[nfs] = c; nfs++; end
      if (a_lr && !prev && lr_r < 0) begin lr_r = c; r_slot = int'(a_slot); r_bit = int'(a_bit); end
      if (!a_lr && prev && lr_f < 0) lr_f = c;
      if (a_lock && lk < 0) lk = c;
      prev = a_lr;
    end
    n_chk++;
    if (nfs != 3 || fs[0] != 8 || fs[1] != 72 || fs[2] != 136) begin
      n_fail++; $display("FAIL i2s_frame_start: got n=%0d %0d,%0d,%0d expected 8,72,136",
        nfs, fs[0], fs[1], fs[2]);
    end
    n_chk++;
    if (lr_r != 32 || r_slot != 0 || r_bit != 3) begin
      n_fail++; $display("FAIL i2s_lr_rise: got cycle %0d slot %0d bit %0d expected 32 0 3", lr_r, r_slot, r_bit);
    end
    n_chk++;
    if (lr_f != 64) begin n_fail++; $display("FAIL i2s_lr_fall: got cycle %0d expected 64", lr_f); end
    n_chk++;
    if (lk != 73) begin n_fail++; $display("FAIL i2s_locked: got cycle %0d expected 73", lk); end
  endtask

  task automatic test_left_justified();
    int lr_r, r_bit, bad, lr_f;
    logic prev;
    do_reset();
    lr_r = -1; r_bit = -1; bad = 0; lr_f = -1; prev = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (c >= 8 && (b_lr !== (b_slot == 1'b1))) bad++;
      if (b_lr && !prev && lr_r < 0) begin lr_r = c; r_bit = int'(b_bit); end
      if (!b_lr && prev && lr_f < 0) lr_f = c;
      prev = b_lr;
    end
    n_chk++;
    if (lr_r != 40 || r_bit != 0) begin
      n_fail++; $display("FAIL lj_lr_rise: got cycle %0d bit %0d expected 40 0", lr_r, r_bit);
    end
    n_chk++;
    if (lr_f != 72) begin n_fail++; $display("FAIL lj_lr_fall: got cycle %0d expected 72", lr_f); end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL lj_lr_tracks_slot: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_tdm();
    int fs1, fs2, nfs, nr, r1, r2, f1, f2;
    logic prev;
    do_reset();
    fs1 = -1; fs2 = -1; nfs = 0; nr = 0; r1 = -1; r2 = -1; f1 = -1; f2 = -1; prev = 1'b0;
    for (int c = 1; c <= 2200; c++) begin
      tick();
      if (c_fs) begin
        nfs++;
        if (nfs == 1) fs1 = c;
        if (nfs == 2) fs2 = c;
      end
      if (c_lr && !prev) begin
        nr++;
        if (nr == 1) r1 = c;
        if (nr == 2) r2 = c;
      end
      if (!c_lr && prev) begin
        if (nr == 1 && f1 < 0) f1 = c;
        if (nr == 2 && f2 < 0) f2 = c;
      end
      prev = c_lr;
    end
    n_chk++;
    if (fs1 != 8 || fs2 != 2056) begin
      n_fail++; $display("FAIL tdm_frame_start: got %0d,%0d expected 8,2056", fs1, fs2);
    end
    n_chk++;
    if (r1 != 8 || f1 != 16) begin
      n_fail++; $display("FAIL tdm_first_fs: got rise %0d fall %0d expected 8 16", r1, f1);
    end
    n_chk++;
    if (r2 != 2048 || f2 != 2056) begin
      n_fail++; $display("FAIL tdm_fs_pulse: got rise %0d fall %0d expected 2048 2056", r2, f2);
    end
  endtask

  task automatic test_fractional();
    localparam int N = 50000;
    longint lo;
    int nr, last, smin, smax;
    do_reset();
    lo = (longint'(N) * longint'(INC_F)) >>> 33;
    nr = 0; last = -1; smin = 1000; smax = 0;
    for (int c = 1; c <= N; c++) begin
      tick();
      if (d_rise) begin
        nr++;
        if (last >= 0) begin
          if (c - last < smin) smin = c - last;
          if (c - last > smax) smax = c - last;
        end
        last = c;
      end
    end
    n_chk++;
    if (longint'(nr) < lo || longint'(nr) > lo + 1) begin
      n_fail++; $display("FAIL frac_rise_count: got %0d expected %0d or %0d", nr, lo, lo + 1);
    end
    n_chk++;
    if (smin != 35 || smax != 36) begin
      n_fail++; $display("FAIL frac_spacing: got min %0d max %0d expected 35 36", smin, smax);
    end
  endtask

  task automatic check_cleared(input string tag);
    n_chk++;
    if ({a_bclk, a_lr, a_rise, a_fall, a_fs, a_lock} !== 6'b0 || a_slot !== 1'b1 || a_bit !== 2'd3) begin
      n_fail++; $display("FAIL %s_cleared: got out=%b slot %0d bit %0d expected 0 1 3",
        tag, {a_bclk, a_lr, a_rise, a_fall, a_fs, a_lock}, a_slot, a_bit);
    end
  endtask

  task automatic check_restart(input string tag);
    int cf;
    cf = -1;
    for (int c = 1; c <= 40 && cf < 0; c++) begin
      tick();
      if (a_fall) begin
        cf = c;
        n_chk++;
        if (a_fs !== 1'b1 || a_slot !== 1'b0 || a_bit !== 2'd0 || a_lock !== 1'b0) begin
          n_fail++; $display("FAIL %s_restart: got fs %b slot %0d bit %0d lock %b expected 1 0 0 0",
            tag, a_fs, a_slot, a_bit, a_lock);
        end
      end
    end
    n_chk++;
    if (cf != 8) begin n_fail++; $display("FAIL %s_restart_latency: got %0d expected 8", tag, cf); end
  endtask

  task automatic test_abort();
    bit hit;
    do_reset();
    hit = 1'b0;
    for (int c = 1; c <= 300 && !hit; c++) begin
      tick();
      if (a_lock && a_slot == 1'b1 && a_bit == 2'd2) hit = 1'b1;
    end
    n_chk++;
    if (!hit) begin n_fail++; $display("FAIL abort_reach_en: got timeout expected slot 1 bit 2 while locked"); end
    en = 1'b0;
    tick();
    check_cleared("abort_en");
    en = 1'b1;
    check_restart("abort_en");
    hit = 1'b0;
    for (int c = 1; c <= 200 && !hit; c++) begin
      tick();
      if (a_slot == 1'b1 && a_bit == 2'd2) hit = 1'b1;
    end
    n_chk++;
    if (!hit) begin n_fail++; $display("FAIL abort_reach_rst: got timeout expected slot 1 bit 2"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("abort_rst");
    check_restart("abort_rst");
  endtask

  initial begin
    test_reset();
    test_i2s();
    test_left_justified();
    test_tdm();
    test_fractional();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
